// File: rtl/pe_acc_requant_pkg.sv
// Shared definitions for the PE accumulator requantisation stage:
// lane geometry, packing mode encodings and lane-count helpers.
package pe_pkg;

  localparam int PIX88_W = 24;
  localparam int PIX18_W = 16;
  localparam int OUT_W   = 8;

  typedef enum logic {
    MODE_88 = 1'b0,
    MODE_18 = 1'b1
  } pe_mode_e;

  function automatic int lane_count(input logic mode);
    return (mode == MODE_18) ? 4 : 2;
  endfunction

  function automatic logic [3:0] lane_mask(input logic mode);
    logic [3:0] m;
    for (int k = 0; k < 4; k++) begin
      m[k] = (k < lane_count(mode));
    end
    return m;
  endfunction

endpackage

// File: rtl/pe_acc_requant_lane.sv
// One requant lane slice, fully combinational: bias add, round-half-up shift,
// optional ReLU and int8 clamp. The parent owns every pipeline register.
module requant_lane import pe_pkg::*; #(
  parameter int LANE_W    = PIX88_W,
  parameter int BIAS_W    = 24,
  parameter int SUM_W     = 26,
  parameter int R_W       = 27,
  parameter int SHIFT_W   = 5,
  parameter int MAX_SHIFT = 23,
  parameter int Q_W       = OUT_W
) (
  input  logic signed [LANE_W-1:0]  lane,
  input  logic signed [BIAS_W-1:0]  bias,
  output logic signed [SUM_W-1:0]   sum,
  input  logic signed [SUM_W-1:0]   sum_in,
  input  logic        [SHIFT_W-1:0] shift,
  output logic signed [R_W-1:0]     r,
  input  logic signed [R_W-1:0]     r_in,
  input  logic                      relu,
  input  logic                      en,
  output logic signed [Q_W-1:0]     q,
  output logic                      sat
);

  localparam logic signed [Q_W-1:0] Q_HI = {1'b0, {(Q_W-1){1'b1}}};
  localparam logic signed [Q_W-1:0] Q_LO = {1'b1, {(Q_W-1){1'b0}}};

  // Adding half an LSB before the arithmetic shift rounds ties toward +inf.
  function automatic logic signed [R_W-1:0] round_shift(
    input logic signed [SUM_W-1:0]   x,
    input logic        [SHIFT_W-1:0] sh
  );
    logic        [SHIFT_W-1:0] s;
    logic signed [R_W-1:0]     half;
    s = (sh > SHIFT_W'(MAX_SHIFT)) ? SHIFT_W'(MAX_SHIFT) : sh;
    if (s == '0) begin
      return R_W'(x);
    end
    half = R_W'(1) <<< (s - SHIFT_W'(1));
    return (R_W'(x) + half) >>> s;
  endfunction

  function automatic logic signed [Q_W-1:0] clamp_q(input logic signed [R_W-1:0] x);
    if (x > R_W'(Q_HI)) begin
      return Q_HI;
    end
    if (x < R_W'(Q_LO)) begin
      return Q_LO;
    end
    return x[Q_W-1:0];
  endfunction

  logic signed [R_W-1:0] r_relu;
  logic signed [Q_W-1:0] q_full;

  always_comb begin
    sum    = SUM_W'(lane) + SUM_W'(bias);
    r      = round_shift(sum_in, shift);
    r_relu = (relu && r_in[R_W-1]) ? '0 : r_in;
    q_full = clamp_q(r_relu);
    sat    = en && (R_W'(q_full) != r_relu);
    q      = en ? q_full : '0;
  end

endmodule

// File: rtl/pe_acc_requant.sv
// Three-stage requantisation of packed PE accumulator words into packed int8
// lanes, with a full-pipeline stall on backpressure and a saturation counter.
module pe_acc_requant #(
  parameter int PE_OUT_W = 64,
  parameter int PIX88_W  = 24,
  parameter int PIX18_W  = 16,
  parameter int BIAS_W   = 24,
  parameter int OUT_W    = 8,
  parameter int SHIFT_W  = 5,
  parameter int CNT_W    = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  in_mode,
  input  logic [PE_OUT_W-1:0]   in_data,
  input  logic [4*BIAS_W-1:0]   in_bias,
  input  logic [SHIFT_W-1:0]    in_shift,
  input  logic                  in_relu,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [4*OUT_W-1:0]    out_data,
  output logic [3:0]            out_mask,
  output logic                  out_mode,
  output logic [CNT_W-1:0]      sat_count
);
  import pe_pkg::*;

  localparam int LANES = 4;
  localparam int SUM_W = PIX88_W + 2;
  localparam int R_W   = SUM_W + 1;

  logic advance;

  logic signed [PIX88_W-1:0] lane_p0 [LANES];
  logic signed [BIAS_W-1:0]  bias_p0 [LANES];
  logic signed [SUM_W-1:0]   sum_p0  [LANES];
  logic [3:0]                mask_p0;

  logic                      vld_p1;
  logic signed [SUM_W-1:0]   sum_p1  [LANES];
  logic [SHIFT_W-1:0]        shift_p1;
  logic                      relu_p1;
  logic [3:0]                mask_p1;
  logic                      mode_p1;
  logic signed [R_W-1:0]     rnd_p1  [LANES];

  logic                      vld_p2;
  logic signed [R_W-1:0]     r_p2    [LANES];
  logic                      relu_p2;
  logic [3:0]                mask_p2;
  logic                      mode_p2;
  logic signed [OUT_W-1:0]   q_p2    [LANES];
  logic [3:0]                sat_p2;
  logic [4*OUT_W-1:0]        data_p2;
  logic [2:0]                pop_p2;
  logic [CNT_W:0]            cnt_sum;
  logic [CNT_W-1:0]          cnt_next;

  assign advance  = !out_valid || out_ready;
  assign in_ready = advance;

  // Lane unpack: mode 0 carries two 24-bit lanes, mode 1 four 16-bit lanes.
  always_comb begin
    mask_p0 = lane_mask(in_mode);
    for (int k = 0; k < LANES; k++) begin
      lane_p0[k] = '0;
      if (in_mode == MODE_18) begin
        lane_p0[k] = signed'(in_data[k*PIX18_W +: PIX18_W]);
      end
      bias_p0[k] = mask_p0[k] ? in_bias[k*BIAS_W +: BIAS_W] : '0;
    end
    if (in_mode == MODE_88) begin
      lane_p0[0] = in_data[PIX88_W-1:0];
      lane_p0[1] = in_data[2*PIX88_W-1:PIX88_W];
    end
  end

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    requant_lane #(
      .LANE_W   (PIX88_W),
      .BIAS_W   (BIAS_W),
      .SUM_W    (SUM_W),
      .R_W      (R_W),
      .SHIFT_W  (SHIFT_W),
      .MAX_SHIFT(PIX88_W - 1),
      .Q_W      (OUT_W)
    ) u_lane (
      .lane  (lane_p0[k]),
      .bias  (bias_p0[k]),
      .sum   (sum_p0[k]),
      .sum_in(sum_p1[k]),
      .shift (shift_p1),
      .r     (rnd_p1[k]),
      .r_in  (r_p2[k]),
      .relu  (relu_p2),
      .en    (mask_p2[k]),
      .q     (q_p2[k]),
      .sat   (sat_p2[k])
    );
  end

  always_comb begin
    pop_p2 = '0;
    for (int k = 0; k < LANES; k++) begin
      data_p2[k*OUT_W +: OUT_W] = q_p2[k];
      pop_p2 = pop_p2 + 3'(sat_p2[k]);
    end
    cnt_sum  = {1'b0, sat_count} + (CNT_W+1)'(pop_p2);
    cnt_next = cnt_sum[CNT_W] ? '1 : cnt_sum[CNT_W-1:0];
  end

  // Control path: valids, output beat and saturation counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      vld_p1    <= 1'b0;
      vld_p2    <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_mask  <= '0;
      out_mode  <= 1'b0;
      sat_count <= '0;
    end else if (advance) begin
      vld_p1    <= in_valid;
      vld_p2    <= vld_p1;
      out_valid <= vld_p2;
      if (vld_p2) begin
        out_data  <= data_p2;
        out_mask  <= mask_p2;
        out_mode  <= mode_p2;
        sat_count <= cnt_next;
      end
    end
  end

  // S1 -> S2 data path; not reset since valids qualify every beat.
  always_ff @(posedge clk) begin
    if (advance) begin
      for (int k = 0; k < LANES; k++) begin
        sum_p1[k] <= sum_p0[k];
        r_p2[k]   <= rnd_p1[k];
      end
      shift_p1 <= in_shift;
      relu_p1  <= in_relu;
      mask_p1  <= mask_p0;
      mode_p1  <= in_mode;
      relu_p2  <= relu_p1;
      mask_p2  <= mask_p1;
      mode_p2  <= mode_p1;
    end
  end

endmodule
